stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter W, default 1, data width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, output channel count (2 <= N <= 16).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port din, input, W, input data.
REQ-007 SHALL have port sel, input, clog2(N), destination channel.
REQ-008 SHALL have port bcast, input, 1, broadcast request; sel is ignored when high.
REQ-009 SHALL have port in_valid, input, 1, input transfer offered.
REQ-010 SHALL have port in_ready, output, 1, input transfer can be accepted.
REQ-011 SHALL have port dout, output, N*W, channel k data at bits [k*W +: W].
REQ-012 SHALL have port out_valid, output, N, per-channel data held.
REQ-013 SHALL have port out_ready, input, N, per-channel consumer ready.
REQ-014 SHALL have port sel_err, output, 1, one-cycle pulse when sel >= N is accepted.

Function
REQ-015 SHALL give each channel a one-entry output register; a transfer occurs on a clk edge with in_valid and in_ready both high.
REQ-016 SHALL define channel k "free" as out_valid[k]==0 or out_ready[k]==1 in the same cycle (simultaneous drain and refill).
REQ-017 SHALL drive in_ready combinationally: unicast = free[sel]; broadcast = AND of all free[k]; sel >= N = 1.
REQ-018 SHALL, on unicast transfer, load din into channel sel and set out_valid[sel] next cycle (1-cycle latency); other channels are unchanged.
REQ-019 SHALL, on broadcast transfer, load din into all N channels and set all out_valid together.
REQ-020 SHALL clear out_valid[k] after an edge with out_valid[k] and out_ready[k] high, unless refilled on the same edge.
REQ-021 SHALL hold dout[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-022 SHALL accept and discard a unicast with sel >= N, setting sel_err high for exactly the following cycle.
REQ-023 SHALL never let in_ready depend on in_valid.

Reset
REQ-024 SHALL, with rst high at a clk edge, clear out_valid to 0, dout to 0 and sel_err to 0 (and counters to 0 when present).
REQ-025 SHALL discard held data when reset arrives mid-operation; any transfer on that edge is lost.

Configuration
REQ-026 SHALL support macro STREAM_DEMUX_CNT_EN; when defined, it adds 16-bit saturating per-channel delivered-word counters. Counters increment on each out_valid & out_ready edge. Readout is via ports cnt_sel (clog2(N) bits, in) and cnt_out (16 bits, out, combinational), plus cnt_clr (1 bit, in, synchronous clear of all counters, with priority over increment).
REQ-027 SHALL, when STREAM_DEMUX_CNT_EN is undefined, omit those ports and all counter logic.

Structure
REQ-028 SHALL put the channel-index width function and the counter width constant (16) in shared package stream_demux_pkg.
REQ-029 SHALL implement each channel register as sub-module stream_demux_slot (load, drain, valid, data), instantiated N times by generate.

Verification
REQ-030 SHALL verify: W=8, N=4, all out_ready=1; send 0xA5 with sel=2 -> next cycle out_valid=0100 and dout[2]=0xA5; following cycle out_valid=0000.
REQ-031 SHALL verify: out_ready[1]=0; send 0x11 then 0x22 to sel=1 -> 0x11 held, in_ready=0 for the second word until out_ready[1]=1, then 0x22 appears with no gap.
REQ-032 SHALL verify: bcast=1, din=0x3C with out_ready=1011 and out_valid[2]=1 -> in_ready=0; raise out_ready[2] -> all four channels load 0x3C together.
REQ-033 SHALL verify: N=3, sel=3, in_valid=1 -> in_ready=1, no out_valid change, sel_err high for exactly one cycle.
REQ-034 SHALL verify: rst asserted while channels 0 and 3 hold data -> next cycle out_valid=0000, dout=0, sel_err=0.
REQ-035 SHALL verify, with STREAM_DEMUX_CNT_EN defined: 5 deliveries on channel 1 -> cnt_sel=1 gives cnt_out=5; cnt_clr -> 0; a counter preloaded to 0xFFFF stays at 0xFFFF after a further delivery.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for stream_demux: channel-index width and counter width.
package stream_demux_pkg;

  localparam int CNT_W = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
module stream_demux_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  // A load on the same edge as a drain keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Unicast/broadcast stream demultiplexer with one register per channel.
// Optional STREAM_DEMUX_CNT_EN adds saturating per-channel delivery counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int W = 1,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        din,
  input  logic [idx_w(N)-1:0] sel,
  input  logic                bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*W-1:0]      dout,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready,
`ifdef STREAM_DEMUX_CNT_EN
  input  logic [idx_w(N)-1:0] cnt_sel,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    cnt_out,
`endif
  output logic                sel_err
);

  localparam int SW = idx_w(N);
  localparam int NP = 2**SW;
  localparam logic [SW:0] NV = (SW+1)'(N);

  logic [N-1:0]  free;
  logic [NP-1:0] free_pad;
  logic [N-1:0]  load;
  logic          oor;
  logic          xfer;

  assign free = ~out_valid | out_ready;
  assign oor  = ({1'b0, sel} >= NV);

  // Out-of-range indices read as free so a bad sel is always swallowed.
  always_comb begin
    free_pad          = '1;
    free_pad[N-1:0]   = free;
  end

  assign in_ready = bcast ? (&free) : free_pad[sel];
  assign xfer     = in_valid & in_ready;

  generate
    for (genvar k = 0; k < N; k++) begin : g_slot
      assign load[k] = xfer & (bcast | (sel == SW'(k)));

      stream_demux_slot #(.W(W)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (load[k]),
        .drain (out_ready[k]),
        .din   (din),
        .valid (out_valid[k]),
        .data  (dout[k*W +: W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) sel_err <= 1'b0;
    else     sel_err <= xfer & ~bcast & oor;
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [N-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]        cnt_pad [NP];

  // Clear wins over increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (out_valid[k] && out_ready[k] && (cnt[k] != '1))
          cnt[k] <= cnt[k] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) cnt_pad[i] = '0;
    for (int k = 0; k < N; k++)  cnt_pad[k] = cnt[k];
  end

  assign cnt_out = cnt_pad[cnt_sel];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux (W=8, N=4 main instance, N=3 instance for bad sel).
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;

  // N=4 instance
  logic [7:0]  din4;
  logic [1:0]  sel4;
  logic        bcast4, iv4, ir4, se4;
  logic [31:0] dout4;
  logic [3:0]  ov4, ordy4;
  // N=3 instance
  logic [7:0]  din3;
  logic [1:0]  sel3;
  logic        bcast3, iv3, ir3, se3;
  logic [23:0] dout3;
  logic [2:0]  ov3, ordy3;
`ifdef STREAM_DEMUX_CNT_EN
  logic [1:0]  cnt_sel4, cnt_sel3;
  logic        cnt_clr4, cnt_clr3;
  logic [15:0] cnt_out4, cnt_out3;
`endif

  stream_demux #(.W(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .sel(sel4), .bcast(bcast4),
    .in_valid(iv4), .in_ready(ir4), .dout(dout4), .out_valid(ov4),
    .out_ready(ordy4),
`ifdef STREAM_DEMUX_CNT_EN
    .cnt_sel(cnt_sel4), .cnt_clr(cnt_clr4), .cnt_out(cnt_out4),
`endif
    .sel_err(se4)
  );

  stream_demux #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel3), .bcast(bcast3),
    .in_valid(iv3), .in_ready(ir3), .dout(dout3), .out_valid(ov3),
    .out_ready(ordy3),
`ifdef STREAM_DEMUX_CNT_EN
    .cnt_sel(cnt_sel3), .cnt_clr(cnt_clr3), .cnt_out(cnt_out3),
`endif
    .sel_err(se3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for dut4: per-channel expected words, checked every cycle.
  logic [7:0] q [4][$];
  logic       err_exp = 1'b0;

  always @(negedge clk) begin : mon
    logic [3:0] mv;
    logic [3:0] mfree;
    logic       mrdy;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        mv[k]    = (q[k].size() != 0);
        mfree[k] = !mv[k] || ordy4[k];
      end
      mrdy = bcast4 ? (&mfree) : mfree[sel4];
      chk("sb_out_valid", 32'(ov4), 32'(mv));
      chk("sb_in_ready", 32'(ir4), 32'(mrdy));
      chk("sb_sel_err", 32'(se4), 32'(err_exp));
      for (int k = 0; k < 4; k++)
        if (mv[k]) chk("sb_dout", 32'(dout4[k*8 +: 8]), 32'(q[k][0]));
      if (rst) begin
        for (int k = 0; k < 4; k++) q[k].delete();
      end else begin
        for (int k = 0; k < 4; k++)
          if (mv[k] && ordy4[k]) void'(q[k].pop_front());
        if (iv4 && mrdy) begin
          if (bcast4) for (int k = 0; k < 4; k++) q[k].push_back(din4);
          else        q[sel4].push_back(din4);
        end
      end
      err_exp = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    din4 = '0; sel4 = '0; bcast4 = 1'b0; iv4 = 1'b0; ordy4 = 4'b1111;
    din3 = '0; sel3 = '0; bcast3 = 1'b0; iv3 = 1'b0; ordy3 = 3'b111;
`ifdef STREAM_DEMUX_CNT_EN
    cnt_sel4 = 2'd1; cnt_clr4 = 1'b0; cnt_sel3 = 2'd0; cnt_clr3 = 1'b0;
`endif
    step(); step();
    chk("rst_ov4", 32'(ov4), 32'h0);
    chk("rst_dout4", dout4, 32'h0);
    chk("rst_se4", 32'(se4), 32'h0);
    chk("rst_ov3", 32'(ov3), 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Unicast with one-cycle latency and immediate drain.
    din4 = 8'hA5; sel4 = 2'd2; iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    chk("t1_ov", 32'(ov4), 32'h4);
    chk("t1_dout2", 32'(dout4[23:16]), 32'hA5);
    step();
    chk("t1_ov_clr", 32'(ov4), 32'h0);

    // Back-pressure on channel 1, then drain and refill on the same edge.
    ordy4 = 4'b1101; din4 = 8'h11; sel4 = 2'd1; iv4 = 1'b1;
    step();
    din4 = 8'h22;
    chk("t2_ir_blk", 32'(ir4), 32'h0);
    chk("t2_hold", 32'(dout4[15:8]), 32'h11);
    step();
    chk("t2_ir_blk2", 32'(ir4), 32'h0);
    chk("t2_hold2", 32'(dout4[15:8]), 32'h11);
    ordy4[1] = 1'b1;
    #1;
    chk("t2_ir_open", 32'(ir4), 32'h1);
    step();
    iv4 = 1'b0;
    chk("t2_ov_nogap", 32'(ov4[1]), 32'h1);
    chk("t2_dout_new", 32'(dout4[15:8]), 32'h22);
    step();
    chk("t2_ov_clr", 32'(ov4), 32'h0);

    // Broadcast blocked by a held channel.
    ordy4 = 4'b1011; din4 = 8'h77; sel4 = 2'd2; iv4 = 1'b1;
    step();
    bcast4 = 1'b1; din4 = 8'h3C;
    #1;
    chk("t3_ir_blk", 32'(ir4), 32'h0);
    step();
    chk("t3_ov_held", 32'(ov4), 32'h4);
    ordy4 = 4'b1111;
    #1;
    chk("t3_ir_open", 32'(ir4), 32'h1);
    step();
    iv4 = 1'b0; bcast4 = 1'b0;
    chk("t3_ov_all", 32'(ov4), 32'hF);
    chk("t3_dout_all", dout4, 32'h3C3C3C3C);
    step();
    chk("t3_ov_clr", 32'(ov4), 32'h0);

    // Reset mid-operation drops held words and the transfer on that edge.
    ordy4 = 4'b0000; din4 = 8'hD0; sel4 = 2'd0; iv4 = 1'b1;
    step();
    din4 = 8'hD3; sel4 = 2'd3;
    step();
    chk("t4_ov_pre", 32'(ov4), 32'h9);
    rst = 1'b1; din4 = 8'h55; sel4 = 2'd1;
    step();
    rst = 1'b0; iv4 = 1'b0;
    chk("t4_ov", 32'(ov4), 32'h0);
    chk("t4_dout", dout4, 32'h0);
    chk("t4_se", 32'(se4), 32'h0);

    // N=3: out-of-range sel is accepted, discarded, and flagged for one cycle.
    sel3 = 2'd3; din3 = 8'h99; iv3 = 1'b1;
    #1;
    chk("t5_ir", 32'(ir3), 32'h1);
    step();
    iv3 = 1'b0;
    chk("t5_ov", 32'(ov3), 32'h0);
    chk("t5_se_hi", 32'(se3), 32'h1);
    step();
    chk("t5_se_lo", 32'(se3), 32'h0);
    sel3 = 2'd2; din3 = 8'h42; iv3 = 1'b1;
    step();
    iv3 = 1'b0;
    chk("t5_ov2", 32'(ov3), 32'h4);
    chk("t5_dout2", 32'(dout3[23:16]), 32'h42);
    chk("t5_se_ok", 32'(se3), 32'h0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      ordy4  = 4'($urandom);
      iv4    = ($urandom_range(0, 3) != 0);
      bcast4 = ($urandom_range(0, 7) == 0);
      sel4   = 2'($urandom);
      din4   = 8'($urandom);
      step();
    end
    iv4 = 1'b0; bcast4 = 1'b0; ordy4 = 4'b1111;
    step(); step();
    chk("rnd_drained", 32'(ov4), 32'h0);

`ifdef STREAM_DEMUX_CNT_EN
    cnt_sel4 = 2'd1; cnt_clr4 = 1'b1;
    step();
    cnt_clr4 = 1'b0;
    chk("c_clr0", 32'(cnt_out4), 32'h0);
    sel4 = 2'd1; iv4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din4 = 8'(i + 1);
      step();
    end
    iv4 = 1'b0;
    step();
    chk("c_five", 32'(cnt_out4), 32'd5);
    cnt_sel4 = 2'd0;
    #1;
    chk("c_ch0", 32'(cnt_out4), 32'd0);
    cnt_sel4 = 2'd1; cnt_clr4 = 1'b1;
    step();
    cnt_clr4 = 1'b0;
    chk("c_clr", 32'(cnt_out4), 32'h0);
    // Clear on the same edge as a delivery wins.
    iv4 = 1'b1;
    step();
    iv4 = 1'b0; cnt_clr4 = 1'b1;
    step();
    cnt_clr4 = 1'b0;
    chk("c_clr_prio", 32'(cnt_out4), 32'h0);
    iv4 = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      din4 = 8'(i);
      step();
    end
    iv4 = 1'b0;
    step();
    chk("c_sat", 32'(cnt_out4), 32'hFFFF);
    iv4 = 1'b1; din4 = 8'hEE;
    step();
    iv4 = 1'b0;
    step();
    chk("c_sat_hold", 32'(cnt_out4), 32'hFFFF);
`endif

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
